sudoku_board_checker: RTL and testbench

//  Parametrised board store plus sequential validity checker for N x N Sudoku (N = BOX*BOX).

---
 rtl/sudoku_pkg.sv | 39 +++
 rtl/sudoku_group_check.sv | 27 ++
 rtl/sudoku_board_checker.sv | 175 +++++++++++++++++
 tb/tb_sudoku_board_checker.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared types and index helpers for the Sudoku board checker.
// Covers FSM states, group kinds, and the mapping of group lanes onto cell indices.
package sudoku_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  typedef enum logic [1:0] {GRP_ROW, GRP_COL, GRP_BOX} grp_type_e;

  function automatic int n_of(input int box);
    return box * box;
  endfunction

  function automatic int cw_of(input int box);
    return $clog2(box * box + 1);
  endfunction

  function automatic int idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

  function automatic grp_type_e grp_type(input int g, input int n);
    if (g < n) return GRP_ROW;
    if (g < 2 * n) return GRP_COL;
    return GRP_BOX;
  endfunction

  // Cell index seen by lane i of group g; boxes are numbered row-major.
  function automatic int member(input int box, input int g, input int i);
    int n;
    int k;
    n = box * box;
    k = g % n;
    case (grp_type(g, n))
      GRP_ROW: return idx(k, i, n);
      GRP_COL: return idx(i, k, n);
      default: return idx((k / box) * box + i / box, (k % box) * box + i % box, n);
    endcase
  endfunction

endpackage

// File: rtl/sudoku_group_check.sv
// Combinational check of one Sudoku group: passes when its N cells hold 1..N exactly once.
module sudoku_group_check #(
  parameter int N  = 9,
  parameter int CW = 4
) (
  input  logic [CW-1:0] cells [N],
  output logic          pass
);

  function automatic logic has_digit(input logic [CW-1:0] c [N], input logic [CW-1:0] d);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (c[i] == d) hit = 1'b1;
    end
    return hit;
  endfunction

  // N cells covering all N digits forces them nonzero, in range and distinct.
  always_comb begin
    pass = 1'b1;
    for (int d = 1; d <= N; d++) begin
      pass = pass & has_digit(cells, CW'(d));
    end
  end

endmodule

// File: rtl/sudoku_board_checker.sv
// Sudoku board store with single-cell edits and a one-group-per-clock validity scan.
// Optional macro SUDOKU_FIRST_ERR_EN adds err_grp/err_vld reporting the first failing group.
module sudoku_board_checker
  import sudoku_pkg::*;
#(
  parameter int  BOX = 3,
  parameter int  CW  = cw_of(BOX),
  localparam int N   = n_of(BOX),
  localparam int NG  = 3 * N,
  localparam int GW  = $clog2(NG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [N*N*CW-1:0] init_board,
  input  logic [N*N-1:0]    init_blank,
  input  logic              wr_en,
  input  logic [3:0]        wr_row,
  input  logic [3:0]        wr_col,
  input  logic [CW-1:0]     wr_data,
  output logic              wr_ack,
  output logic              wr_rej,
  input  logic              chk_start,
  output logic              chk_busy,
  output logic              chk_done,
  output logic              valid,
`ifdef SUDOKU_FIRST_ERR_EN
  output logic [GW-1:0]     err_grp,
  output logic              err_vld,
`endif
  output logic [N*N*CW-1:0] board,
  output logic [N*N-1:0]    board_blank
);

  localparam logic [4:0]    N_IDX    = 5'(N);
  localparam logic [CW-1:0] N_VAL    = CW'(N);
  localparam logic [GW-1:0] LAST_GRP = GW'(NG - 1);

  state_e        state;
  logic [GW-1:0] grp;
  logic          acc;
  logic          grp_pass;
  logic          edit_range;
  logic          wr_ok;
  logic          wr_bad;
  logic          scan_start;
  logic [N*N-1:0] wr_hit;
  logic [CW-1:0] cell_w [N*N];
  logic [CW-1:0] grp_cells_all [NG][N];
  logic [CW-1:0] grp_cells [N];

  assign edit_range = ({1'b0, wr_row} < N_IDX) && ({1'b0, wr_col} < N_IDX) && (wr_data <= N_VAL);
  assign wr_ok      = wr_en && !load && (state != SCAN) && edit_range && |(wr_hit & board_blank);
  assign wr_bad     = wr_en && !load && !wr_ok;
  assign scan_start = !load && chk_start && (state != SCAN);

  // Board store: load beats edits, edits only land on blank cells.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam int J = idx(r, c, N);
      logic [CW-1:0] cell_q;
      logic          blank_q;

      assign wr_hit[J] = (wr_row == 4'(r)) && (wr_col == 4'(c));

      always_ff @(posedge clk) begin
        if (!reset) begin
          cell_q  <= '0;
          blank_q <= 1'b0;
        end else if (load) begin
          cell_q  <= init_board[J*CW +: CW];
          blank_q <= init_blank[J];
        end else if (wr_ok && wr_hit[J]) begin
          cell_q  <= wr_data;
        end
      end

      assign cell_w[J]             = cell_q;
      assign board[J*CW +: CW]     = cell_q;
      assign board_blank[J]        = blank_q;
    end
  end

  // Group mux: every group's lanes are wired statically, grp picks one.
  for (genvar g = 0; g < NG; g++) begin : g_grp
    for (genvar i = 0; i < N; i++) begin : g_lane
      assign grp_cells_all[g][i] = cell_w[member(BOX, g, i)];
    end
  end

  assign grp_cells = grp_cells_all[grp];

  sudoku_group_check #(
    .N  (N),
    .CW (CW)
  ) u_group_check (
    .cells (grp_cells),
    .pass  (grp_pass)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      grp      <= '0;
      acc      <= 1'b0;
      valid    <= 1'b0;
      chk_busy <= 1'b0;
      chk_done <= 1'b0;
      wr_ack   <= 1'b0;
      wr_rej   <= 1'b0;
    end else begin
      wr_ack   <= wr_ok;
      wr_rej   <= wr_bad;
      chk_done <= 1'b0;
      if (load) begin
        state    <= IDLE;
        grp      <= '0;
        chk_busy <= 1'b0;
        valid    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (scan_start) begin
              state    <= SCAN;
              grp      <= '0;
              acc      <= 1'b1;
              chk_busy <= 1'b1;
            end
          end
          SCAN: begin
            acc <= acc & grp_pass;
            if (grp == LAST_GRP) begin
              state    <= DONE;
              grp      <= '0;
              chk_busy <= 1'b0;
            end else begin
              grp <= grp + GW'(1);
            end
          end
          DONE: begin
            chk_done <= 1'b1;
            valid    <= acc;
            if (scan_start) begin
              state    <= SCAN;
              grp      <= '0;
              acc      <= 1'b1;
              chk_busy <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
        // An edit landing alongside the result still makes it stale.
        if (wr_ok) valid <= 1'b0;
      end
    end
  end

`ifdef SUDOKU_FIRST_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_grp <= '0;
      err_vld <= 1'b0;
    end else if (scan_start) begin
      err_grp <= '0;
      err_vld <= 1'b0;
    end else if (!load && (state == SCAN) && !grp_pass && !err_vld) begin
      err_grp <= grp;
      err_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sudoku_board_checker.sv
// Self-checking bench for sudoku_board_checker: 9x9 instance plus a 16x16 instance.
module tb_sudoku_board_checker;

  localparam int NN9  = 81;
  localparam int NN16 = 256;

  typedef struct {
    int    row;
    int    col;
    int    data;
    logic  ack;
    string name;
  } edit_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic load, wr_en, chk_start;
  logic [NN9*4-1:0] init_board;
  logic [NN9-1:0]   init_blank;
  logic [3:0] wr_row, wr_col, wr_data;
  logic wr_ack, wr_rej, chk_busy, chk_done, valid;
  logic [NN9*4-1:0] board;
  logic [NN9-1:0]   board_blank;

  logic load16, wr_en16, chk_start16;
  logic [NN16*5-1:0] init16;
  logic [NN16-1:0]   blank16_in;
  logic [3:0] wr_row16, wr_col16;
  logic [4:0] wr_data16;
  logic wr_ack16, wr_rej16, chk_busy16, chk_done16, valid16;
  logic [NN16*5-1:0] board16;
  logic [NN16-1:0]   board_blank16;

`ifdef SUDOKU_FIRST_ERR_EN
  logic [4:0] err_grp;
  logic       err_vld;
  logic [5:0] err_grp16;
  logic       err_vld16;
`endif

  sudoku_board_checker #(.BOX(3)) dut (
    .clk(clk), .reset(reset), .load(load), .init_board(init_board), .init_blank(init_blank),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_rej(wr_rej), .chk_start(chk_start), .chk_busy(chk_busy),
    .chk_done(chk_done), .valid(valid),
`ifdef SUDOKU_FIRST_ERR_EN
    .err_grp(err_grp), .err_vld(err_vld),
`endif
    .board(board), .board_blank(board_blank)
  );

  sudoku_board_checker #(.BOX(4)) dut16 (
    .clk(clk), .reset(reset), .load(load16), .init_board(init16), .init_blank(blank16_in),
    .wr_en(wr_en16), .wr_row(wr_row16), .wr_col(wr_col16), .wr_data(wr_data16),
    .wr_ack(wr_ack16), .wr_rej(wr_rej16), .chk_start(chk_start16), .chk_busy(chk_busy16),
    .chk_done(chk_done16), .valid(valid16),
`ifdef SUDOKU_FIRST_ERR_EN
    .err_grp(err_grp16), .err_vld(err_vld16),
`endif
    .board(board16), .board_blank(board_blank16)
  );

  int checks = 0;
  int errors = 0;
  logic exp_edit_q [$];
  logic exp_valid_q [$];
  logic [NN9*4-1:0] model;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  task automatic check_board(input string name);
    checks++;
    if (board !== model) begin
      errors++;
      for (int i = 0; i < NN9; i++) begin
        if (board[i*4 +: 4] !== model[i*4 +: 4]) begin
          $display("FAIL %s cell %0d actual=%0d required=%0d", name, i, board[i*4 +: 4], model[i*4 +: 4]);
          break;
        end
      end
    end
  endtask

  function automatic logic [NN9*4-1:0] solved9();
    logic [NN9*4-1:0] g;
    g = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        g[(r*9+c)*4 +: 4] = 4'((3*(r%3) + r/3 + c) % 9 + 1);
    return g;
  endfunction

  function automatic logic [NN16*5-1:0] solved16();
    logic [NN16*5-1:0] g;
    g = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        g[(r*16+c)*5 +: 5] = 5'((4*(r%4) + r/4 + c) % 16 + 1);
    return g;
  endfunction

  // Scoreboard: responses popped as the 9x9 DUT produces them.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (chk_done) begin
        if (exp_valid_q.size() == 0) fail_now("unexpected chk_done");
        else check("scan valid", valid, exp_valid_q.pop_front());
      end
      if (wr_ack || wr_rej) begin
        if (exp_edit_q.size() == 0) begin
          fail_now("unexpected edit response");
        end else begin
          logic e;
          e = exp_edit_q.pop_front();
          check("edit ack/rej", {wr_ack, wr_rej}, {e, !e});
        end
      end
    end
  end

  task automatic do_load(input logic [NN9*4-1:0] g, input logic [NN9-1:0] b);
    load = 1'b1;
    init_board = g;
    init_blank = b;
    tick();
    load = 1'b0;
    model = g;
  endtask

  task automatic do_edit(input int r, input int c, input int d, input logic exp_ack);
    wr_row = 4'(r);
    wr_col = 4'(c);
    wr_data = 4'(d);
    wr_en = 1'b1;
    exp_edit_q.push_back(exp_ack);
    tick();
    wr_en = 1'b0;
    if (exp_ack) model[(r*9+c)*4 +: 4] = 4'(d);
    tick();
  endtask

  // Any wr_en already driven is applied in the same cycle as chk_start.
  task automatic run_scan(input string name, input logic exp_valid, input int restart_at);
    int n;
    int busy;
    exp_valid_q.push_back(exp_valid);
    chk_start = 1'b1;
    tick();
    chk_start = 1'b0;
    wr_en = 1'b0;
    n = 0;
    busy = chk_busy ? 1 : 0;
    while (n < 200) begin
      chk_start = (n == restart_at);
      tick();
      n++;
      if (chk_done) break;
      if (chk_busy) busy++;
    end
    chk_start = 1'b0;
    check({name, " done latency"}, n, 28);
    check({name, " busy cycles"}, busy, 27);
    tick();
    check({name, " done pulse width"}, chk_done, 0);
  endtask

  initial begin
    edit_vec_t tbl [7];
    logic [NN9*4-1:0] g;
    logic [NN9-1:0]   blank;
    int n;
    int busy;
    int dones;

    tbl[0] = '{4, 4, 5,  1'b1, "blank (4,4)<=5"};
    tbl[1] = '{0, 0, 3,  1'b0, "fixed (0,0)"};
    tbl[2] = '{9, 0, 1,  1'b0, "row 9"};
    tbl[3] = '{4, 4, 10, 1'b0, "data 10"};
    tbl[4] = '{4, 9, 1,  1'b0, "col 9"};
    tbl[5] = '{4, 4, 0,  1'b1, "clear (4,4)"};
    tbl[6] = '{4, 4, 9,  1'b1, "restore (4,4)<=9"};

    reset = 1'b0;
    load = 1'b0; wr_en = 1'b0; chk_start = 1'b0;
    init_board = '0; init_blank = '0; wr_row = '0; wr_col = '0; wr_data = '0;
    load16 = 1'b0; wr_en16 = 1'b0; chk_start16 = 1'b0;
    init16 = '0; blank16_in = '0; wr_row16 = '0; wr_col16 = '0; wr_data16 = '0;
    model = '0;
    tick();
    tick();

    check("reset board", (board == '0) ? 1 : 0, 1);
    check("reset blank", (board_blank == '0) ? 1 : 0, 1);
    check("reset busy", chk_busy, 0);
    check("reset done", chk_done, 0);
    check("reset valid", valid, 0);
    check("reset ack/rej", {wr_ack, wr_rej}, 0);
    check("reset busy16", chk_busy16, 0);
    reset = 1'b1;
    tick();

    // Solved grid, with a chk_start retrigger mid-scan that must be ignored.
    blank = '0;
    blank[4*9+4] = 1'b1;
    do_load(solved9(), blank);
    check_board("load solved");
    check("load blank mask", board_blank, blank);
    run_scan("solved", 1'b1, 5);
`ifdef SUDOKU_FIRST_ERR_EN
    check("solved err_vld", err_vld, 0);
`endif

    // Editing table; rejected entries must leave the board alone.
    for (int i = 0; i < 7; i++) begin
      do_edit(tbl[i].row, tbl[i].col, tbl[i].data, tbl[i].ack);
      check_board(tbl[i].name);
      if (i == 0) check("valid stale after edit", valid, 0);
    end
    run_scan("restored", 1'b1, -1);

    // Swapped (0,0)/(0,1): rows intact, column 0 is the first failure.
    g = solved9();
    g[3:0] = 4'd2;
    g[7:4] = 4'd1;
    do_load(g, blank);
    run_scan("swapped", 1'b0, -1);
`ifdef SUDOKU_FIRST_ERR_EN
    check("swapped err_vld", err_vld, 1);
    check("swapped err_grp", err_grp, 9);
`endif

    // Edit refused mid-scan, then load aborts the scan.
    do_load(solved9(), blank);
    run_scan("pre-abort", 1'b1, -1);
    chk_start = 1'b1;
    tick();
    chk_start = 1'b0;
    tick();
    tick();
    wr_row = 4'd4; wr_col = 4'd4; wr_data = 4'd1; wr_en = 1'b1;
    exp_edit_q.push_back(1'b0);
    tick();
    wr_en = 1'b0;
    repeat (6) tick();
    check("busy at scan cycle 10", chk_busy, 1);
    load = 1'b1;
    tick();
    load = 1'b0;
    check("abort busy", chk_busy, 0);
    check("abort valid", valid, 0);
    check_board("abort board");
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (chk_done) dones++;
    end
    check("abort no chk_done", dones, 0);

    // load and wr_en together: load wins, no edit response.
    load = 1'b1; wr_en = 1'b1; wr_row = 4'd4; wr_col = 4'd4; wr_data = 4'd3;
    tick();
    load = 1'b0; wr_en = 1'b0;
    check("load+edit ack/rej", {wr_ack, wr_rej}, 0);
    check_board("load+edit board");

    // Empty cell fails; filling it in the chk_start cycle makes the scan pass.
    g = solved9();
    g[80*4 +: 4] = 4'd0;
    blank = '0;
    blank[80] = 1'b1;
    do_load(g, blank);
    run_scan("one empty", 1'b0, -1);
    wr_row = 4'd8; wr_col = 4'd8; wr_data = 4'd8; wr_en = 1'b1;
    exp_edit_q.push_back(1'b1);
    model[80*4 +: 4] = 4'd8;
    run_scan("filled", 1'b1, -1);
    check_board("filled board");

    // 16x16 instance: latency 3N+1, then reset mid-scan.
    load16 = 1'b1;
    init16 = solved16();
    tick();
    load16 = 1'b0;
    chk_start16 = 1'b1;
    tick();
    chk_start16 = 1'b0;
    n = 0;
    busy = chk_busy16 ? 1 : 0;
    while (n < 200) begin
      tick();
      n++;
      if (chk_done16) break;
      if (chk_busy16) busy++;
    end
    check("16x16 done latency", n, 49);
    check("16x16 busy cycles", busy, 48);
    check("16x16 valid", valid16, 1);
    chk_start16 = 1'b1;
    tick();
    chk_start16 = 1'b0;
    repeat (10) tick();
    check("16x16 busy mid-scan", chk_busy16, 1);
    reset = 1'b0;
    tick();
    check("mid-scan reset busy16", chk_busy16, 0);
    check("mid-scan reset done16", chk_done16, 0);
    check("mid-scan reset valid16", valid16, 0);
    check("mid-scan reset board16", (board16 == '0) ? 1 : 0, 1);
    check("mid-scan reset ack/rej16", {wr_ack16, wr_rej16}, 0);
    check("mid-scan reset valid", valid, 0);
    reset = 1'b1;
    tick();

    check("edit queue drained", exp_edit_q.size(), 0);
    check("scan queue drained", exp_valid_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
